// File: rtl/axi4_2to1_arbiter_if.sv
// Signal bundle between two upstream AXI4 masters, the 2:1 arbiter and one downstream slave.
// Per-master upstream fields are packed {master1, master0}.
interface axi4_2to1_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int ID_W   = 3
);
  localparam int STRB_W = DATA_W / 8;

  logic [1:0]          in_aw_valid, in_aw_ready;
  logic [2*ID_W-1:0]   in_aw_id;
  logic [2*ADDR_W-1:0] in_aw_addr;
  logic [15:0]         in_aw_len;
  logic [5:0]          in_aw_size;
  logic [3:0]          in_aw_burst;

  logic [1:0]          in_w_valid, in_w_ready;
  logic [2*DATA_W-1:0] in_w_data;
  logic [2*STRB_W-1:0] in_w_strb;
  logic [1:0]          in_w_last;

  logic [1:0]          in_b_valid, in_b_ready;
  logic [ID_W-1:0]     in_b_id;
  logic [1:0]          in_b_resp;

  logic [1:0]          in_ar_valid, in_ar_ready;
  logic [2*ID_W-1:0]   in_ar_id;
  logic [2*ADDR_W-1:0] in_ar_addr;
  logic [15:0]         in_ar_len;
  logic [5:0]          in_ar_size;
  logic [3:0]          in_ar_burst;

  logic [1:0]          in_r_valid, in_r_ready;
  logic [ID_W-1:0]     in_r_id;
  logic [DATA_W-1:0]   in_r_data;
  logic [1:0]          in_r_resp;
  logic                in_r_last;

  logic                out_aw_valid, out_aw_ready;
  logic [ID_W:0]       out_aw_id;
  logic [ADDR_W-1:0]   out_aw_addr;
  logic [7:0]          out_aw_len;
  logic [2:0]          out_aw_size;
  logic [1:0]          out_aw_burst;

  logic                out_w_valid, out_w_ready;
  logic [DATA_W-1:0]   out_w_data;
  logic [STRB_W-1:0]   out_w_strb;
  logic                out_w_last;

  logic                out_b_valid, out_b_ready;
  logic [ID_W:0]       out_b_id;
  logic [1:0]          out_b_resp;

  logic                out_ar_valid, out_ar_ready;
  logic [ID_W:0]       out_ar_id;
  logic [ADDR_W-1:0]   out_ar_addr;
  logic [7:0]          out_ar_len;
  logic [2:0]          out_ar_size;
  logic [1:0]          out_ar_burst;

  logic                out_r_valid, out_r_ready;
  logic [ID_W:0]       out_r_id;
  logic [DATA_W-1:0]   out_r_data;
  logic [1:0]          out_r_resp;
  logic                out_r_last;

  // Arbiter view.
  modport slave (
    input  in_aw_valid, in_aw_id, in_aw_addr, in_aw_len, in_aw_size, in_aw_burst,
    output in_aw_ready,
    input  in_w_valid, in_w_data, in_w_strb, in_w_last,
    output in_w_ready,
    output in_b_valid, in_b_id, in_b_resp,
    input  in_b_ready,
    input  in_ar_valid, in_ar_id, in_ar_addr, in_ar_len, in_ar_size, in_ar_burst,
    output in_ar_ready,
    output in_r_valid, in_r_id, in_r_data, in_r_resp, in_r_last,
    input  in_r_ready,
    output out_aw_valid, out_aw_id, out_aw_addr, out_aw_len, out_aw_size, out_aw_burst,
    input  out_aw_ready,
    output out_w_valid, out_w_data, out_w_strb, out_w_last,
    input  out_w_ready,
    input  out_b_valid, out_b_id, out_b_resp,
    output out_b_ready,
    output out_ar_valid, out_ar_id, out_ar_addr, out_ar_len, out_ar_size, out_ar_burst,
    input  out_ar_ready,
    input  out_r_valid, out_r_id, out_r_data, out_r_resp, out_r_last,
    output out_r_ready
  );

  // Environment view: upstream masters plus downstream slave.
  modport master (
    output in_aw_valid, in_aw_id, in_aw_addr, in_aw_len, in_aw_size, in_aw_burst,
    input  in_aw_ready,
    output in_w_valid, in_w_data, in_w_strb, in_w_last,
    input  in_w_ready,
    input  in_b_valid, in_b_id, in_b_resp,
    output in_b_ready,
    output in_ar_valid, in_ar_id, in_ar_addr, in_ar_len, in_ar_size, in_ar_burst,
    input  in_ar_ready,
    input  in_r_valid, in_r_id, in_r_data, in_r_resp, in_r_last,
    output in_r_ready,
    input  out_aw_valid, out_aw_id, out_aw_addr, out_aw_len, out_aw_size, out_aw_burst,
    output out_aw_ready,
    input  out_w_valid, out_w_data, out_w_strb, out_w_last,
    output out_w_ready,
    output out_b_valid, out_b_id, out_b_resp,
    input  out_b_ready,
    input  out_ar_valid, out_ar_id, out_ar_addr, out_ar_len, out_ar_size, out_ar_burst,
    output out_ar_ready,
    output out_r_valid, out_r_id, out_r_data, out_r_resp, out_r_last,
    input  out_r_ready
  );
endinterface

// File: rtl/axi4_2to1_arbiter.sv
// Two-master to one-slave AXI4 arbiter: round-robin AW/AR with grant lock, W routed by an
// AW-order FIFO, B/R returned by the extra MSB of the slave-side ID. All paths combinational.
module axi4_2to1_arbiter #(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 3,
  parameter int WQ_DEPTH = 2
) (
  input logic clock,
  input logic reset,
  axi4_2to1_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(WQ_DEPTH);
  localparam int CNT_W  = $clog2(WQ_DEPTH + 1);

  logic             aw_ptr, aw_lock, aw_lock_idx, aw_sel, aw_hs;
  logic             ar_ptr, ar_lock, ar_lock_idx, ar_sel, ar_hs;
  logic             wq_mem [WQ_DEPTH];
  logic [PTR_W-1:0] wq_wr, wq_rd;
  logic [CNT_W-1:0] wq_cnt;
  logic             wq_full, wq_empty, wq_head, w_pop;
  logic             b_dst, r_dst;

  function automatic logic rr_pick(input logic lock, input logic lock_idx,
                                   input logic ptr, input logic [1:0] vld);
    if (lock)      return lock_idx;
    if (vld[ptr])  return ptr;
    if (vld[!ptr]) return !ptr;
    return ptr;
  endfunction

  assign aw_sel   = rr_pick(aw_lock, aw_lock_idx, aw_ptr, bus.in_aw_valid);
  assign ar_sel   = rr_pick(ar_lock, ar_lock_idx, ar_ptr, bus.in_ar_valid);
  // Full comes from registered count only, so a pop this cycle never frees a slot for a push.
  assign wq_full  = (wq_cnt == CNT_W'(WQ_DEPTH));
  assign wq_empty = (wq_cnt == '0);
  assign wq_head  = wq_mem[wq_rd];

  // AW channel
  assign bus.out_aw_valid = !reset && bus.in_aw_valid[aw_sel] && !wq_full;
  assign bus.out_aw_id    = {aw_sel, aw_sel ? bus.in_aw_id[2*ID_W-1:ID_W] : bus.in_aw_id[ID_W-1:0]};
  assign bus.out_aw_addr  = aw_sel ? bus.in_aw_addr[2*ADDR_W-1:ADDR_W] : bus.in_aw_addr[ADDR_W-1:0];
  assign bus.out_aw_len   = aw_sel ? bus.in_aw_len[15:8] : bus.in_aw_len[7:0];
  assign bus.out_aw_size  = aw_sel ? bus.in_aw_size[5:3] : bus.in_aw_size[2:0];
  assign bus.out_aw_burst = aw_sel ? bus.in_aw_burst[3:2] : bus.in_aw_burst[1:0];
  assign aw_hs            = bus.out_aw_valid && bus.out_aw_ready;

  always_comb begin
    bus.in_aw_ready         = '0;
    bus.in_aw_ready[aw_sel] = !reset && bus.out_aw_ready && !wq_full;
  end

  // AR channel
  assign bus.out_ar_valid = !reset && bus.in_ar_valid[ar_sel];
  assign bus.out_ar_id    = {ar_sel, ar_sel ? bus.in_ar_id[2*ID_W-1:ID_W] : bus.in_ar_id[ID_W-1:0]};
  assign bus.out_ar_addr  = ar_sel ? bus.in_ar_addr[2*ADDR_W-1:ADDR_W] : bus.in_ar_addr[ADDR_W-1:0];
  assign bus.out_ar_len   = ar_sel ? bus.in_ar_len[15:8] : bus.in_ar_len[7:0];
  assign bus.out_ar_size  = ar_sel ? bus.in_ar_size[5:3] : bus.in_ar_size[2:0];
  assign bus.out_ar_burst = ar_sel ? bus.in_ar_burst[3:2] : bus.in_ar_burst[1:0];
  assign ar_hs            = bus.out_ar_valid && bus.out_ar_ready;

  always_comb begin
    bus.in_ar_ready         = '0;
    bus.in_ar_ready[ar_sel] = !reset && bus.out_ar_ready;
  end

  // W channel: only the FIFO head master may drive, and only once its AW has been accepted.
  assign bus.out_w_valid = !reset && !wq_empty && bus.in_w_valid[wq_head];
  assign bus.out_w_data  = wq_head ? bus.in_w_data[2*DATA_W-1:DATA_W] : bus.in_w_data[DATA_W-1:0];
  assign bus.out_w_strb  = wq_head ? bus.in_w_strb[2*STRB_W-1:STRB_W] : bus.in_w_strb[STRB_W-1:0];
  assign bus.out_w_last  = bus.in_w_last[wq_head];
  assign w_pop           = bus.out_w_valid && bus.out_w_ready && bus.out_w_last;

  always_comb begin
    bus.in_w_ready          = '0;
    bus.in_w_ready[wq_head] = !reset && !wq_empty && bus.out_w_ready;
  end

  // B and R: ID MSB names the originating master.
  assign b_dst            = bus.out_b_id[ID_W];
  assign bus.in_b_id      = bus.out_b_id[ID_W-1:0];
  assign bus.in_b_resp    = bus.out_b_resp;
  assign bus.out_b_ready  = !reset && bus.in_b_ready[b_dst];
  assign r_dst            = bus.out_r_id[ID_W];
  assign bus.in_r_id      = bus.out_r_id[ID_W-1:0];
  assign bus.in_r_data    = bus.out_r_data;
  assign bus.in_r_resp    = bus.out_r_resp;
  assign bus.in_r_last    = bus.out_r_last;
  assign bus.out_r_ready  = !reset && bus.in_r_ready[r_dst];

  always_comb begin
    bus.in_b_valid        = '0;
    bus.in_b_valid[b_dst] = !reset && bus.out_b_valid;
    bus.in_r_valid        = '0;
    bus.in_r_valid[r_dst] = !reset && bus.out_r_valid;
  end

  // Control state: pointers, locks, FIFO pointers/count
  always_ff @(posedge clock) begin
    if (reset) begin
      aw_ptr      <= 1'b0;
      aw_lock     <= 1'b0;
      aw_lock_idx <= 1'b0;
      ar_ptr      <= 1'b0;
      ar_lock     <= 1'b0;
      ar_lock_idx <= 1'b0;
      wq_wr       <= '0;
      wq_rd       <= '0;
      wq_cnt      <= '0;
    end else begin
      if (aw_hs) begin
        aw_ptr  <= !aw_sel;
        aw_lock <= 1'b0;
      end else if (bus.out_aw_valid) begin
        aw_lock     <= 1'b1;
        aw_lock_idx <= aw_sel;
      end
      if (ar_hs) begin
        ar_ptr  <= !ar_sel;
        ar_lock <= 1'b0;
      end else if (bus.out_ar_valid) begin
        ar_lock     <= 1'b1;
        ar_lock_idx <= ar_sel;
      end
      if (aw_hs) wq_wr <= wq_wr + PTR_W'(1);
      if (w_pop) wq_rd <= wq_rd + PTR_W'(1);
      case ({aw_hs, w_pop})
        2'b10:   wq_cnt <= wq_cnt + CNT_W'(1);
        2'b01:   wq_cnt <= wq_cnt - CNT_W'(1);
        default: wq_cnt <= wq_cnt;
      endcase
    end
  end

  // FIFO storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (aw_hs) wq_mem[wq_wr] <= aw_sel;
  end
endmodule

// File: tb/tb_axi4_2to1_arbiter.sv
// Directed bench for axi4_2to1_arbiter: vector tables for arbitration and response routing,
// hand sequences for grant lock, FIFO backpressure, W/AW same-cycle and mid-traffic reset.
module tb_axi4_2to1_arbiter;
  localparam int ADDR_W = 30, DATA_W = 32, ID_W = 3, WQ_DEPTH = 2;
  localparam logic [ADDR_W-1:0] A0  = 30'h0000_1000;
  localparam logic [ADDR_W-1:0] A1  = 30'h0000_2000;
  localparam logic [DATA_W-1:0] WD0 = 32'hA0A0_0000;
  localparam logic [DATA_W-1:0] WD1 = 32'hB1B1_0001;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   q[$];

  axi4_2to1_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();
  axi4_2to1_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .WQ_DEPTH(WQ_DEPTH))
    dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] vld;
    logic       rdy;
    logic       exp_v;
    logic [3:0] exp_id;
    logic [1:0] exp_rdy;
  } rr_vec_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] rdy;
    logic [1:0] exp_v;
    logic [2:0] exp_id;
    logic       exp_rdy;
  } rt_vec_t;

  rr_vec_t rr_tab[12];
  rt_vec_t rt_tab[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_aw_valid = '0;  bus.in_ar_valid = '0;
    bus.in_aw_id = {3'd5, 3'd3};  bus.in_ar_id = {3'd5, 3'd3};
    bus.in_aw_addr = {A1, A0};    bus.in_ar_addr = {A1, A0};
    bus.in_aw_len = {8'd3, 8'd3}; bus.in_ar_len = {8'd3, 8'd3};
    bus.in_aw_size = {3'd2, 3'd2}; bus.in_ar_size = {3'd2, 3'd2};
    bus.in_aw_burst = {2'd1, 2'd1}; bus.in_ar_burst = {2'd1, 2'd1};
    bus.in_w_valid = '0;  bus.in_w_last = '0;
    bus.in_w_data = {WD1, WD0};  bus.in_w_strb = {4'hC, 4'h3};
    bus.in_b_ready = '0;  bus.in_r_ready = '0;
    bus.out_aw_ready = 1'b0;  bus.out_ar_ready = 1'b0;  bus.out_w_ready = 1'b0;
    bus.out_b_valid = 1'b0;  bus.out_b_id = '0;  bus.out_b_resp = '0;
    bus.out_r_valid = 1'b0;  bus.out_r_id = '0;  bus.out_r_data = '0;
    bus.out_r_resp = '0;  bus.out_r_last = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] wd(input int m);
    return (m != 0) ? WD1 : WD0;
  endfunction

  initial begin
    // ids: M0 -> {0,3} = 4'h3, M1 -> {1,5} = 4'hD
    rr_tab[0]  = '{2'b11, 1'b1, 1'b1, 4'h3, 2'b01};
    rr_tab[1]  = '{2'b11, 1'b1, 1'b1, 4'hD, 2'b10};
    rr_tab[2]  = '{2'b11, 1'b1, 1'b1, 4'h3, 2'b01};
    rr_tab[3]  = '{2'b11, 1'b1, 1'b1, 4'hD, 2'b10};
    rr_tab[4]  = '{2'b10, 1'b1, 1'b1, 4'hD, 2'b10};
    rr_tab[5]  = '{2'b10, 1'b1, 1'b1, 4'hD, 2'b10};
    rr_tab[6]  = '{2'b01, 1'b1, 1'b1, 4'h3, 2'b01};
    rr_tab[7]  = '{2'b01, 1'b1, 1'b1, 4'h3, 2'b01};
    rr_tab[8]  = '{2'b00, 1'b1, 1'b0, 4'hD, 2'b10};
    rr_tab[9]  = '{2'b11, 1'b0, 1'b1, 4'hD, 2'b00};
    rr_tab[10] = '{2'b11, 1'b1, 1'b1, 4'hD, 2'b10};
    rr_tab[11] = '{2'b11, 1'b1, 1'b1, 4'h3, 2'b01};

    rt_tab[0] = '{4'b1010, 2'b10, 2'b10, 3'b010, 1'b1};
    rt_tab[1] = '{4'b1010, 2'b01, 2'b10, 3'b010, 1'b0};
    rt_tab[2] = '{4'b0101, 2'b01, 2'b01, 3'b101, 1'b1};
    rt_tab[3] = '{4'b0111, 2'b10, 2'b01, 3'b111, 1'b0};
    rt_tab[4] = '{4'b1000, 2'b11, 2'b10, 3'b000, 1'b1};

    clear_inputs();
    tick();
    // Reset: everything active on the inputs, all handshake outputs must be low.
    bus.in_aw_valid = 2'b11;  bus.out_aw_ready = 1'b1;
    bus.in_ar_valid = 2'b11;  bus.out_ar_ready = 1'b1;
    bus.in_w_valid = 2'b11;   bus.out_w_ready = 1'b1;
    bus.out_b_valid = 1'b1;   bus.in_b_ready = 2'b11;
    bus.out_r_valid = 1'b1;   bus.in_r_ready = 2'b11;
    #1;
    chk("rst_out_aw_valid", bus.out_aw_valid, 0);
    chk("rst_in_aw_ready", bus.in_aw_ready, 0);
    chk("rst_out_ar_valid", bus.out_ar_valid, 0);
    chk("rst_in_ar_ready", bus.in_ar_ready, 0);
    chk("rst_out_w_valid", bus.out_w_valid, 0);
    chk("rst_in_w_ready", bus.in_w_ready, 0);
    chk("rst_in_b_valid", bus.in_b_valid, 0);
    chk("rst_out_b_ready", bus.out_b_ready, 0);
    chk("rst_in_r_valid", bus.in_r_valid, 0);
    chk("rst_out_r_ready", bus.out_r_ready, 0);

    // Round-robin table; W drains one burst per cycle so the FIFO order is observable.
    apply_reset();
    bus.in_w_valid = 2'b11;  bus.in_w_last = 2'b11;  bus.out_w_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 12; i++) begin
      bus.in_aw_valid = rr_tab[i].vld;  bus.out_aw_ready = rr_tab[i].rdy;
      bus.in_ar_valid = rr_tab[i].vld;  bus.out_ar_ready = rr_tab[i].rdy;
      #1;
      chk("rr_aw_valid", bus.out_aw_valid, rr_tab[i].exp_v);
      chk("rr_aw_id", bus.out_aw_id, rr_tab[i].exp_id);
      chk("rr_aw_addr", bus.out_aw_addr, rr_tab[i].exp_id[3] ? A1 : A0);
      chk("rr_aw_ready", bus.in_aw_ready, rr_tab[i].exp_rdy);
      chk("rr_ar_valid", bus.out_ar_valid, rr_tab[i].exp_v);
      chk("rr_ar_id", bus.out_ar_id, rr_tab[i].exp_id);
      chk("rr_ar_ready", bus.in_ar_ready, rr_tab[i].exp_rdy);
      if (q.size() > 0) begin
        chk("rr_w_valid", bus.out_w_valid, 1);
        chk("rr_w_data", bus.out_w_data, wd(q[0]));
      end else begin
        chk("rr_w_valid_empty", bus.out_w_valid, 0);
      end
      tick();
      if (q.size() > 0) void'(q.pop_front());
      if (rr_tab[i].exp_v && rr_tab[i].rdy) q.push_back(int'(rr_tab[i].exp_id[3]));
    end

    // Grant lock: M0 held for 3 stalled cycles while pointer prefers M1.
    apply_reset();
    bus.in_w_valid = 2'b11;  bus.in_w_last = 2'b11;  bus.out_w_ready = 1'b1;
    bus.in_aw_valid = 2'b01;  bus.out_aw_ready = 1'b1;
    #1; chk("lk_first_ready", bus.in_aw_ready, 2'b01);
    tick();
    bus.out_aw_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) bus.in_aw_valid = 2'b11;
      #1;
      chk("lk_hold_id", bus.out_aw_id, 4'h3);
      chk("lk_hold_addr", bus.out_aw_addr, A0);
      chk("lk_hold_ready", bus.in_aw_ready, 2'b00);
      tick();
    end
    bus.out_aw_ready = 1'b1;
    #1; chk("lk_m0_hs", bus.in_aw_ready, 2'b01);
    tick();
    bus.in_aw_valid = 2'b10;
    #1;
    chk("lk_m1_id", bus.out_aw_id, 4'hD);
    chk("lk_m1_ready", bus.in_aw_ready, 2'b10);
    tick();

    // FIFO full: two AWs accepted with W stalled, third blocked until M0's 4-beat burst ends.
    apply_reset();
    bus.in_w_valid = 2'b11;  bus.out_aw_ready = 1'b1;
    bus.in_aw_valid = 2'b01;
    #1; chk("fu_aw1_ready", bus.in_aw_ready, 2'b01);
    tick();
    bus.in_aw_valid = 2'b10;
    #1; chk("fu_aw2_ready", bus.in_aw_ready, 2'b10);
    tick();
    bus.in_aw_valid = 2'b01;
    #1;
    chk("fu_aw3_valid", bus.out_aw_valid, 0);
    chk("fu_aw3_ready", bus.in_aw_ready, 2'b00);
    chk("fu_w_valid", bus.out_w_valid, 1);
    chk("fu_w_data", bus.out_w_data, WD0);
    chk("fu_w_ready_stall", bus.in_w_ready, 2'b00);
    tick();
    bus.out_w_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.in_w_last = (b == 3) ? 2'b01 : 2'b00;
      #1;
      chk("fu_beat_ready", bus.in_w_ready, 2'b01);
      chk("fu_beat_data", bus.out_w_data, WD0);
      chk("fu_beat_last", bus.out_w_last, (b == 3) ? 1 : 0);
      chk("fu_beat_aw_blocked", bus.in_aw_ready, 2'b00);
      tick();
    end
    bus.in_w_last = 2'b00;
    #1;
    chk("fu_aw3_accept", bus.in_aw_ready, 2'b01);
    chk("fu_aw3_valid_now", bus.out_aw_valid, 1);
    chk("fu_head_m1_data", bus.out_w_data, WD1);
    chk("fu_head_m1_ready", bus.in_w_ready, 2'b10);
    tick();

    // AW and W of M1 in the same cycle with an empty FIFO.
    apply_reset();
    bus.in_aw_valid = 2'b10;  bus.out_aw_ready = 1'b1;
    bus.in_w_valid = 2'b10;   bus.in_w_last = 2'b10;  bus.out_w_ready = 1'b1;
    #1;
    chk("sc_w_valid0", bus.out_w_valid, 0);
    chk("sc_w_ready0", bus.in_w_ready, 2'b00);
    chk("sc_aw_ready", bus.in_aw_ready, 2'b10);
    tick();
    bus.in_aw_valid = 2'b00;
    #1;
    chk("sc_w_valid1", bus.out_w_valid, 1);
    chk("sc_w_data1", bus.out_w_data, WD1);
    chk("sc_w_ready1", bus.in_w_ready, 2'b10);
    tick();
    #1; chk("sc_w_valid2", bus.out_w_valid, 0);

    // B/R response routing table.
    for (int i = 0; i < 5; i++) begin
      bus.out_b_valid = 1'b1;  bus.out_b_id = rt_tab[i].id;  bus.out_b_resp = 2'b10;
      bus.in_b_ready = rt_tab[i].rdy;
      bus.out_r_valid = 1'b1;  bus.out_r_id = rt_tab[i].id;  bus.out_r_resp = 2'b01;
      bus.out_r_data = 32'hDEAD_0000 | 32'(i);  bus.out_r_last = 1'b1;
      bus.in_r_ready = rt_tab[i].rdy;
      #1;
      chk("rt_b_valid", bus.in_b_valid, rt_tab[i].exp_v);
      chk("rt_b_id", bus.in_b_id, rt_tab[i].exp_id);
      chk("rt_b_resp", bus.in_b_resp, 2'b10);
      chk("rt_b_ready", bus.out_b_ready, rt_tab[i].exp_rdy);
      chk("rt_r_valid", bus.in_r_valid, rt_tab[i].exp_v);
      chk("rt_r_id", bus.in_r_id, rt_tab[i].exp_id);
      chk("rt_r_data", bus.in_r_data, 32'hDEAD_0000 | 32'(i));
      chk("rt_r_ready", bus.out_r_ready, rt_tab[i].exp_rdy);
      tick();
    end

    // Reset in the middle of an R burst with AW locked on M1 and pointer at M1.
    apply_reset();
    bus.in_aw_valid = 2'b01;  bus.out_aw_ready = 1'b1;
    tick();
    bus.in_aw_valid = 2'b10;  bus.out_aw_ready = 1'b0;
    bus.out_r_valid = 1'b1;   bus.out_r_id = 4'b1001;  bus.in_r_ready = 2'b11;
    #1; chk("mr_pre_r_valid", bus.in_r_valid, 2'b10);
    tick();
    reset = 1'b1;
    tick();
    chk("mr_r_valid", bus.in_r_valid, 0);
    chk("mr_r_ready", bus.out_r_ready, 0);
    chk("mr_aw_valid", bus.out_aw_valid, 0);
    chk("mr_aw_ready", bus.in_aw_ready, 0);
    reset = 1'b0;
    bus.in_aw_valid = 2'b11;  bus.out_aw_ready = 1'b0;
    bus.in_w_valid = 2'b11;   bus.in_w_last = 2'b11;  bus.out_w_ready = 1'b1;
    #1;
    chk("mr_post_sel_m0", bus.out_aw_id, 4'h3);
    chk("mr_post_w_valid", bus.out_w_valid, 0);
    chk("mr_post_w_ready", bus.in_w_ready, 2'b00);
    tick();
    bus.out_aw_ready = 1'b1;
    #1; chk("mr_post_hs_m0", bus.in_aw_ready, 2'b01);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
